// File: rtl/vm_pkg.sv
// vm_pkg: coin indices, denominations and dispenser states shared by the vending machine blocks.
package vm_pkg;
  localparam int NUM_COINS = 5;
  typedef enum logic [2:0] {COIN_10, COIN_20, COIN_50, COIN_100, COIN_200} coin_e;
  localparam logic [NUM_COINS-1:0][7:0] COIN_VAL = {8'd200, 8'd100, 8'd50, 8'd20, 8'd10};
  typedef enum logic [2:0] {ST_IDLE, ST_SELECT, ST_EJECT, ST_GAP, ST_DONE} disp_state_e;
  function automatic logic [NUM_COINS-1:0] coin_onehot(input coin_e c);
    return NUM_COINS'(1) << c;
  endfunction
endpackage

// File: rtl/change_coin_select.sv
// change_coin_select: picks the highest non-empty denomination that fits the remaining amount.
module change_coin_select
  import vm_pkg::*;
(
  input  logic [7:0]           remaining,
  input  logic [NUM_COINS-1:0] hopper_empty,
  output logic                 found,
  output coin_e                coin_idx
);
  always_comb begin
    found = 1'b0;
    coin_idx = COIN_10;
    for (int i = 0; i < NUM_COINS; i++)
      if (!hopper_empty[i] && COIN_VAL[i] <= remaining) begin
        found = 1'b1;
        coin_idx = coin_e'(3'(i));
      end
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount as coins, largest first, one solenoid pulse per coin,
// reporting any amount that cannot be paid as owed.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int PULSE_CYCLES = 3,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 change_valid,
  input  logic [7:0]           change_amt,
  input  logic [NUM_COINS-1:0] hopper_empty,
  output logic [NUM_COINS-1:0] coin_eject,
  output logic                 busy,
  output logic                 done,
  output logic                 shortfall,
  output logic [7:0]           owed,
  output logic                 req_drop
);
  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  disp_state_e r_state, w_state_nx;
  coin_e r_coin, w_coin_nx, w_sel_idx;
  logic [7:0] r_remaining, w_remaining_nx, r_owed, w_owed_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [NUM_COINS-1:0] r_eject, w_eject_nx;
  logic r_short, w_short_nx, w_sel_found;
  change_coin_select u_sel (
    .remaining   (r_remaining),
    .hopper_empty(hopper_empty),
    .found       (w_sel_found),
    .coin_idx    (w_sel_idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_coin      <= COIN_10;
      r_remaining <= '0;
      r_owed      <= '0;
      r_cnt       <= '0;
      r_eject     <= '0;
      r_short     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_coin      <= w_coin_nx;
      r_remaining <= w_remaining_nx;
      r_owed      <= w_owed_nx;
      r_cnt       <= w_cnt_nx;
      r_eject     <= w_eject_nx;
      r_short     <= w_short_nx;
    end
  // Solenoid drive is precomputed from the next state so it comes straight off a flop.
  always_comb begin
    w_state_nx     = r_state;
    w_coin_nx      = r_coin;
    w_remaining_nx = r_remaining;
    w_owed_nx      = r_owed;
    w_cnt_nx       = r_cnt;
    w_eject_nx     = '0;
    w_short_nx     = r_short;
    case (r_state)
      ST_IDLE:
        if (change_valid) begin
          w_remaining_nx = change_amt;
          w_short_nx     = 1'b0;
          w_owed_nx      = '0;
          w_state_nx     = ST_SELECT;
        end
      ST_SELECT:
        if (r_remaining == '0) w_state_nx = ST_DONE;
        else if (w_sel_found) begin
          w_coin_nx  = w_sel_idx;
          w_cnt_nx   = '0;
          w_eject_nx = coin_onehot(w_sel_idx);
          w_state_nx = ST_EJECT;
        end else begin
          w_owed_nx  = r_remaining;
          w_short_nx = 1'b1;
          w_state_nx = ST_DONE;
        end
      ST_EJECT:
        if (r_cnt == CW'(PULSE_CYCLES - 1)) begin
          w_remaining_nx = r_remaining - COIN_VAL[r_coin];
          w_cnt_nx       = '0;
          w_state_nx     = (GAP_CYCLES == 0) ? ST_SELECT : ST_GAP;
        end else begin
          w_cnt_nx   = r_cnt + CW'(1);
          w_eject_nx = coin_onehot(r_coin);
        end
      ST_GAP: begin
        w_cnt_nx   = (r_cnt == CW'(GAP_CYCLES - 1)) ? '0 : r_cnt + CW'(1);
        w_state_nx = (r_cnt == CW'(GAP_CYCLES - 1)) ? ST_SELECT : ST_GAP;
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end
  assign coin_eject = r_eject;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign shortfall  = r_short;
  assign owed       = r_owed;
  assign req_drop   = change_valid && (r_state != ST_IDLE);
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed payout scenarios with hand-computed cycle-by-cycle expectations.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic change_valid = 1'b0;
  logic [7:0] change_amt = '0;
  logic [4:0] hopper_empty = '0;
  logic [4:0] coin_eject;
  logic busy, done, shortfall, req_drop;
  logic [7:0] owed;
  int n_asserts = 0;
  int n_fail = 0;
  change_dispenser #(.PULSE_CYCLES(3), .GAP_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .change_valid(change_valid),
    .change_amt  (change_amt),
    .hopper_empty(hopper_empty),
    .coin_eject  (coin_eject),
    .busy        (busy),
    .done        (done),
    .shortfall   (shortfall),
    .owed        (owed),
    .req_drop    (req_drop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic start(input logic [7:0] amt);
    change_amt = amt;
    change_valid = 1'b1;
    cyc();
    change_valid = 1'b0;
  endtask
  task automatic hold(input string tag, input logic [4:0] ej, input int n);
    for (int k = 0; k < n; k++) begin
      chk({tag, " eject"}, 32'(coin_eject), 32'(ej));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " done"}, 32'(done), 32'd0);
      cyc();
    end
  endtask
  task automatic fin(input string tag, input logic sf, input logic [7:0] ow);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy@done"}, 32'(busy), 32'd1);
    chk({tag, " shortfall"}, 32'(shortfall), 32'(sf));
    chk({tag, " owed"}, 32'(owed), 32'(ow));
    chk({tag, " eject@done"}, 32'(coin_eject), 32'd0);
    cyc();
    chk({tag, " done end"}, 32'(done), 32'd0);
    chk({tag, " busy end"}, 32'(busy), 32'd0);
    chk({tag, " shortfall held"}, 32'(shortfall), 32'(sf));
    chk({tag, " owed held"}, 32'(owed), 32'(ow));
  endtask
  initial begin
    repeat (2) cyc();
    chk("rst eject", 32'(coin_eject), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst shortfall", 32'(shortfall), 32'd0);
    chk("rst owed", 32'(owed), 32'd0);
    chk("rst req_drop", 32'(req_drop), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle busy", 32'(busy), 32'd0);
    // 150c all full: 100c then 50c
    start(8'd150);
    hold("150 sel", 5'b00000, 1);
    hold("150 c100", 5'b01000, 3);
    hold("150 gap1", 5'b00000, 3);
    hold("150 c50", 5'b00100, 3);
    hold("150 gap2", 5'b00000, 3);
    fin("150", 1'b0, 8'd0);
    // 200c with 2 euro hopper empty: two 100c coins
    hopper_empty = 5'b10000;
    start(8'd200);
    hold("200 sel", 5'b00000, 1);
    hold("200 c100a", 5'b01000, 3);
    hold("200 gap1", 5'b00000, 3);
    hold("200 c100b", 5'b01000, 3);
    hold("200 gap2", 5'b00000, 3);
    fin("200", 1'b0, 8'd0);
    // 30c with 10c hopper empty: 20c, 10c owed
    hopper_empty = 5'b00001;
    start(8'd30);
    hold("30 sel", 5'b00000, 1);
    hold("30 c20", 5'b00010, 3);
    hold("30 gap", 5'b00000, 3);
    fin("30", 1'b1, 8'd10);
    // 25c all full: 20c, 5c residue owed
    hopper_empty = 5'b00000;
    start(8'd25);
    hold("25 sel", 5'b00000, 1);
    hold("25 c20", 5'b00010, 3);
    hold("25 gap", 5'b00000, 3);
    fin("25", 1'b1, 8'd5);
    // 0c: done two cycles after strobe, previous shortfall cleared on accept
    start(8'd0);
    chk("0 shortfall cleared", 32'(shortfall), 32'd0);
    chk("0 owed cleared", 32'(owed), 32'd0);
    hold("0 sel", 5'b00000, 1);
    fin("0", 1'b0, 8'd0);
    // 70c with an 80c request during the second coin
    start(8'd70);
    hold("70 sel", 5'b00000, 1);
    hold("70 c50", 5'b00100, 3);
    hold("70 gap1", 5'b00000, 3);
    change_amt = 8'd80;
    change_valid = 1'b1;
    #1;
    chk("drop pulse", 32'(req_drop), 32'd1);
    chk("drop c20", 32'(coin_eject), 32'b00010);
    cyc();
    change_valid = 1'b0;
    #1;
    chk("drop end", 32'(req_drop), 32'd0);
    hold("70 c20", 5'b00010, 2);
    hold("70 gap2", 5'b00000, 3);
    fin("70", 1'b0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      chk("no 80 busy", 32'(busy), 32'd0);
      chk("no 80 eject", 32'(coin_eject), 32'd0);
      cyc();
    end
    // reset during the first eject cycle of 100c
    start(8'd100);
    hold("rst100 sel", 5'b00000, 1);
    chk("rst100 eject", 32'(coin_eject), 32'b01000);
    #2 rst_n = 1'b0;
    #1;
    chk("async eject", 32'(coin_eject), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post rst busy", 32'(busy), 32'd0);
    chk("post rst eject", 32'(coin_eject), 32'd0);
    start(8'd10);
    hold("10 sel", 5'b00000, 1);
    hold("10 c10", 5'b00001, 3);
    hold("10 gap", 5'b00000, 3);
    fin("10", 1'b0, 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending machine: takes the change amount the vending machine produces and pays it out as physical coins. It drives one eject solenoid per coin hopper (10c, 20c, 50c, 1€, 2€), largest coin first, skipping empty hoppers. It reports any amount it cannot pay, so the machine can log it as owed credit.

## Interface
Parameters:
- `PULSE_CYCLES`, default 3: cycles one eject solenoid is held high per coin (≥1).
- `GAP_CYCLES`, default 2: idle cycles between consecutive coins (≥0).

Ports:
- `clk`, in, 1: single clock, all logic on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `change_valid`, in, 1: one-cycle strobe; `change_amt` is valid.
- `change_amt`, in, 8: change to pay, in cents (0–255).
- `hopper_empty`, in, 5: bit i high means hopper i is empty. Index 0=10c, 1=20c, 2=50c, 3=100c, 4=200c.
- `coin_eject`, out, 5: one-hot solenoid drive, same indexing as `hopper_empty`.
- `busy`, out, 1: high from the cycle after a request is accepted until `done`.
- `done`, out, 1: one-cycle pulse when a payout ends.
- `shortfall`, out, 1: valid with `done` and held until the next accept. High means not all change was paid.
- `owed`, out, 8: unpaid cents, held until the next accept. 0 on full payout.
- `req_drop`, out, 1: one-cycle pulse when `change_valid` arrives while `busy`.

## Operation
- States: IDLE, SELECT, EJECT, GAP, DONE.
- IDLE: on `change_valid`, load `remaining <= change_amt`, clear `shortfall` and `owed`, go to SELECT.
- SELECT, one cycle, evaluates `hopper_empty` in this cycle:
  - `remaining == 0`: go to DONE.
  - Otherwise pick the highest denomination d with d ≤ `remaining` and its hopper not empty. Go to EJECT with d latched.
  - No such coin: set `owed <= remaining` and `shortfall <= 1`, then go to DONE.
- EJECT: `coin_eject[d]` is high for exactly `PULSE_CYCLES` cycles. On the last cycle, `remaining <= remaining - d`.
- After EJECT, go to GAP for `GAP_CYCLES` cycles, then SELECT. If `GAP_CYCLES == 0`, go straight to SELECT.
- DONE: `done` is high for one cycle, then go to IDLE.
- Change that is not a multiple of 10 leaves a residue (< 10c). It ends the payout as a shortfall with `owed` = the residue.
- An emptiness change during EJECT or GAP has no effect on the coin in flight. It is taken into account at the next SELECT.
- `change_valid` in any state other than IDLE:
  - The request is ignored and `req_drop` pulses.
  - This includes the DONE cycle.
  - The payout in progress is unaffected.
- Subtraction never underflows, because d ≤ `remaining` is guaranteed by SELECT. 8-bit unsigned arithmetic throughout.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `coin_eject = 0`, `busy = 0`, `done = 0`, `shortfall = 0`, `owed = 0`, `req_drop = 0`, `remaining = 0`.
- A reset mid-EJECT drops the solenoid drive in the same instant and discards the rest of the payout.
- For `change_valid` at cycle 0:
  - SELECT at cycle 1.
  - First `coin_eject` high at cycles 2 … 1+`PULSE_CYCLES`.
  - Each further coin follows after `GAP_CYCLES` + 1 (SELECT) cycles.
- `change_amt = 0`: SELECT at cycle 1, `done` at cycle 2, no eject.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- `coin_eject` is registered, glitch-free, and at most one bit is high in any cycle.

## Structure
- Shared package `vm_pkg`:
  - coin index enum: `COIN_10`, `COIN_20`, `COIN_50`, `COIN_100`, `COIN_200`.
  - denomination value constants array (8-bit cents).
  - `NUM_COINS = 5`.
  - dispenser state enum.
- One sub-module, `change_coin_select`. It is purely combinational: inputs `remaining` and `hopper_empty`; outputs `found` and `coin_idx` (highest eligible coin).
- The top level holds the FSM, `remaining`, and the pulse and gap counter (width from `$clog2` of max(`PULSE_CYCLES`, `GAP_CYCLES`)+1).

## Test plan
Run with `PULSE_CYCLES = 3`, `GAP_CYCLES = 2` unless noted.
- 150c, all hoppers full: exactly one 100c pulse then one 50c pulse, each 3 cycles with a 3-cycle spacing. `done` with `shortfall = 0`, `owed = 0`.
- 200c with `hopper_empty[4] = 1`: two 100c pulses, then `done`, `shortfall = 0`.
- 30c with `hopper_empty[0] = 1`: one 20c pulse, then `done` with `shortfall = 1`, `owed = 10`.
- 25c, all hoppers full: one 20c pulse, then `shortfall = 1`, `owed = 5`. Then 0c: `done` 2 cycles after the strobe, no eject, `shortfall` and `owed` cleared.
- `change_valid` (80c) during the second coin of a 70c payout: `req_drop` pulses for one cycle. The 70c payout (50c, 20c) completes unchanged and no 80c payout follows.
- `rst_n` low during the first EJECT cycle of a 100c payout: `coin_eject = 0` immediately, and the block is in IDLE after release. The next 10c request pays exactly one 10c coin.
